baud_generator_frac: RTL

- Parametrised fractional baud-rate generator for the UART datapath.
- Produces an oversample-rate enable (en_os_baud_o) and a 1x bit-rate enable (en_baud_o) from a divisor with integer and fractional parts.
- Divisor changes are glitch-free: new values are double-buffered and applied on a period boundary.
- sync_i re-phases the generator so RX logic can align sampling to a detected start-bit edge.

---
 rtl/baud_generator_frac.sv | 124 ++++++++++++
 1 files changed

// File: rtl/baud_generator_frac.sv
// Fractional baud-rate generator.
// Produces an oversample-rate tick and a 1x bit-rate tick from an integer +
// fractional divisor. Divisor updates are double-buffered and take effect on
// a period boundary; sync_i restarts the phase for start-bit alignment.
module baud_generator_frac #(
  parameter int unsigned             CNT_W    = 16,
  parameter int unsigned             FRAC_W   = 4,
  parameter int unsigned             OS_RATE  = 16,
  parameter logic [CNT_W-1:0]        DEF_INT  = 16'd27,
  parameter logic [FRAC_W-1:0]       DEF_FRAC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              cfg_load_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              cfg_pending_o,
  output logic              en_os_baud_o,
  output logic              en_baud_o
);

  localparam int unsigned OS_W = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);

  // Active and pending divisor registers
  logic [CNT_W-1:0]  r_int_a;
  logic [FRAC_W-1:0] r_frac_a;
  logic [CNT_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_pending;

  // Timing state
  logic [CNT_W:0]    r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [OS_W-1:0]   r_os_cnt;
  logic              r_os_tick;
  logic              r_baud_tick;

  logic [CNT_W:0]    w_int_eff;
  logic [CNT_W:0]    w_period_m1;
  logic [FRAC_W:0]   w_acc_sum;
  logic              w_run;
  logic              w_wrap;
  logic              w_apply;

  // Period length, wrap detection and the pending-divisor apply condition
  always_comb begin
    w_int_eff   = (r_int_a == '0) ? (CNT_W+1)'(1) : {1'b0, r_int_a};
    // P-1 = int_eff + carry - 1, never negative because int_eff >= 1
    w_period_m1 = w_int_eff + (CNT_W+1)'(r_carry) - (CNT_W+1)'(1);
    w_acc_sum   = {1'b0, r_acc} + {1'b0, r_frac_a};
    w_run       = en_i && !sync_i;
    w_wrap      = w_run && (r_cnt == w_period_m1);
    // A waiting divisor is applied on a wrap, or at once when the generator
    // is idle or being re-phased, since no period is in flight then.
    w_apply     = r_pending && (w_wrap || !w_run);
  end

  // Configuration double-buffer: capture on load, transfer to active on apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_a     <= DEF_INT;
      r_frac_a    <= DEF_FRAC;
      r_pend_int  <= '0;
      r_pend_frac <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_int_a  <= r_pend_int;
        r_frac_a <= r_pend_frac;
      end
      // A load on the same edge as an apply stays pending for the next one
      if (cfg_load_i) begin
        r_pend_int  <= div_int_i;
        r_pend_frac <= div_frac_i;
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Period counter, fractional accumulator, oversample counter and ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (!w_run) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_os_tick <= 1'b1;
      {r_carry, r_acc} <= w_acc_sum;
      if (r_os_cnt == OS_LAST) begin
        r_os_cnt    <= '0;
        r_baud_tick <= 1'b1;
      end else begin
        r_os_cnt    <= r_os_cnt + 1'b1;
        r_baud_tick <= 1'b0;
      end
    end else begin
      r_cnt       <= r_cnt + 1'b1;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end
  end

  assign cfg_pending_o = r_pending;
  assign en_os_baud_o  = r_os_tick;
  assign en_baud_o     = r_baud_tick;

endmodule
